// File: rtl/dsi_pkg.sv
// Shared types for the DSI lane scheduler slice.
// Holds the FSM state enum, lane enable helper and bus widths.
package dsi_pkg;

  localparam int WC_W_DEF = 16;
  localparam int SHORT_W  = 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_START,
    S_WAIT,
    S_GAP
  } state_t;

  // cfg_lanes holds lane count minus one; result is a thermometer mask.
  function automatic logic [3:0] lanes_to_en(input logic [1:0] l);
    logic [3:0] en;
    en = 4'b0000;
    unique case (l)
      2'd0: en = 4'b0001;
      2'd1: en = 4'b0011;
      2'd2: en = 4'b0111;
      2'd3: en = 4'b1111;
      default: en = 4'b0000;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/dsi_lane_scheduler_if.sv
// Packet-source bundle between the packet builders and the scheduler.
// master = packet builders (req/data out, done in); slave = scheduler.
interface dsi_lane_scheduler_if #(
  parameter int WC_W = 16
);
  import dsi_pkg::*;

  logic               cmd_req;
  logic [SHORT_W-1:0] cmd_pkt;
  logic               vid_req;
  logic [WC_W-1:0]    vid_wc;
  logic               cmd_done;
  logic               vid_done;

  modport master (
    output cmd_req, cmd_pkt, vid_req, vid_wc,
    input  cmd_done, vid_done
  );

  modport slave (
    input  cmd_req, cmd_pkt, vid_req, vid_wc,
    output cmd_done, vid_done
  );

endinterface

// File: rtl/dsi_sched_arb.sv
// Two-way arbiter: video first, command after STARVE_MAX video wins.
// Ports: clk/rst, cmd_req, vid_req, gnt_en (grant cycle), gnt_vid/gnt_cmd.
module dsi_sched_arb #(
  parameter int STARVE_MAX = 3
) (
  input  logic dsi_clk,
  input  logic dsi_rst_n,
  input  logic cmd_req,
  input  logic vid_req,
  input  logic gnt_en,
  output logic gnt_vid,
  output logic gnt_cmd
);

  localparam int SW = $clog2(STARVE_MAX + 2);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  logic [SW-1:0] starve_cnt;
  logic          starved;

  assign starved = cmd_req && (starve_cnt == SMAX);
  assign gnt_vid = vid_req && !starved;
  assign gnt_cmd = cmd_req && !gnt_vid;

  always_ff @(posedge dsi_clk) begin
    if (!dsi_rst_n) begin
      starve_cnt <= '0;
    end else if (gnt_en && (gnt_vid || gnt_cmd)) begin
      if (gnt_vid && cmd_req)
        starve_cnt <= (starve_cnt == SMAX) ?
                      SMAX : starve_cnt + SW'(1);
      else
        starve_cnt <= '0;
    end
  end

endmodule

// File: rtl/dsi_lane_scheduler.sv
// Grants one short/long packet at a time to the PPI lane datapath.
// Ports: dsi_clk/rst_n, cfg_lanes, src bundle, lane_done, pkt_*, lane_en, busy, timeout_err.
module dsi_lane_scheduler
  import dsi_pkg::*;
#(
  parameter int WC_W       = WC_W_DEF,
  parameter int TIMEOUT    = 4096,
  parameter int GAP_CYCLES = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic                 dsi_clk,
  input  logic                 dsi_rst_n,
  input  logic [1:0]           cfg_lanes,
  dsi_lane_scheduler_if.slave  src,
  input  logic                 lane_done,
  output logic                 pkt_start,
  output logic                 pkt_is_long,
  output logic [WC_W-1:0]      pkt_wc,
  output logic [SHORT_W-1:0]   pkt_short,
  output logic [3:0]           lane_en,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int CW = $clog2(TIMEOUT);
  // Compared before the increment, so the timeout fires on the
  // edge where the counter would reach TIMEOUT-1.
  localparam logic [CW-1:0] WLAST = CW'(TIMEOUT - 2);
  localparam logic [7:0]    GLAST = 8'(GAP_CYCLES - 1);

  state_t        state;
  logic [CW-1:0] wcnt;
  logic [7:0]    gcnt;
  logic          gnt_vid;
  logic          gnt_cmd;

  dsi_sched_arb #(
    .STARVE_MAX(STARVE_MAX)
  ) u_arb (
    .dsi_clk  (dsi_clk),
    .dsi_rst_n(dsi_rst_n),
    .cmd_req  (src.cmd_req),
    .vid_req  (src.vid_req),
    .gnt_en   (state == S_GRANT),
    .gnt_vid  (gnt_vid),
    .gnt_cmd  (gnt_cmd)
  );

  always_ff @(posedge dsi_clk) begin
    if (!dsi_rst_n) begin
      state        <= S_IDLE;
      wcnt         <= '0;
      gcnt         <= '0;
      pkt_start    <= 1'b0;
      pkt_is_long  <= 1'b0;
      pkt_wc       <= '0;
      pkt_short    <= '0;
      lane_en      <= '0;
      busy         <= 1'b0;
      timeout_err  <= 1'b0;
      src.cmd_done <= 1'b0;
      src.vid_done <= 1'b0;
    end else begin
      pkt_start    <= 1'b0;
      src.cmd_done <= 1'b0;
      src.vid_done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (src.cmd_req || src.vid_req) begin
            state <= S_GRANT;
            busy  <= 1'b1;
          end
        end
        S_GRANT: begin
          if (gnt_vid || gnt_cmd) begin
            pkt_is_long <= gnt_vid;
            pkt_wc      <= gnt_vid ? src.vid_wc : '0;
            if (gnt_cmd)
              pkt_short <= src.cmd_pkt;
            lane_en     <= lanes_to_en(cfg_lanes);
            pkt_start   <= 1'b1;
            state       <= S_START;
          end else begin
            // Request vanished before arbitration.
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        S_START: begin
          wcnt  <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (lane_done || wcnt == WLAST) begin
            if (!lane_done)
              timeout_err <= 1'b1;
            src.cmd_done <= !pkt_is_long;
            src.vid_done <= pkt_is_long;
            lane_en      <= '0;
            gcnt         <= '0;
            state        <= S_GAP;
          end else begin
            wcnt <= wcnt + CW'(1);
          end
        end
        S_GAP: begin
          if (gcnt == GLAST) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            gcnt <= gcnt + 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
